// File: rtl/fetch_if.sv
// fetch_if: redirect, stall, instruction-memory and IF/ID signals of the fetch stage.
// Rev 1.0
`default_nettype none

interface fetch_if #(
  parameter int PC_W    = 9,
  parameter int INSTR_W = 32
);
  logic               stall;
  logic               PcSel;
  logic [31:0]        BrPC;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               if_valid;
  logic               misalign_err;
  logic [31:0]        fetch_count;

  modport master (
    input  stall, PcSel, BrPC, imem_rdata,
    output imem_addr, imem_en, if_pc, if_instr, if_valid, misalign_err, fetch_count
  );

  modport slave (
    output stall, PcSel, BrPC, imem_rdata,
    input  imem_addr, imem_en, if_pc, if_instr, if_valid, misalign_err, fetch_count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and instruction fetch with stall-hold, redirect flush and fetch counter.
// Rev 1.0
`default_nettype none

module fetch_stage #(
  parameter int          PC_W     = 9,
  parameter int          INSTR_W  = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_INIT = RESET_PC[PC_W-1:0];
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_t             state_q;
  state_t             state_d;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    req_pc;
  logic               req_valid;
  logic               hold_valid;
  logic [INSTR_W-1:0] hold_instr;
  logic               pcsel_q;
  logic               misalign_q;
  logic [31:0]        count_q;
  logic               if_valid;
  logic               accept;
  logic               unused_br_hi;

  // Upper redirect-target bits are deliberately ignored.
  assign unused_br_hi = ^bus.BrPC[31:PC_W];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:     state_d = bus.PcSel ? REDIRECT : RUN;
      RUN:      state_d = bus.PcSel ? REDIRECT : RUN;
      REDIRECT: state_d = bus.PcSel ? REDIRECT : RUN;
      default:  state_d = BOOT;
    endcase
  end

  assign if_valid = req_valid && (state_q != BOOT) && !pcsel_q;
  assign accept   = if_valid && !bus.stall && !bus.PcSel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= PC_INIT;
      req_pc     <= '0;
      req_valid  <= 1'b0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
      pcsel_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pcsel_q    <= bus.PcSel;
      misalign_q <= bus.PcSel && (|bus.BrPC[1:0]);
      if (accept) begin
        count_q <= count_q + 32'd1;
      end
      if (bus.PcSel) begin
        pc_q       <= {bus.BrPC[PC_W-1:2], 2'b00};
        req_valid  <= 1'b0;
        hold_valid <= 1'b0;
      end else if (bus.stall) begin
        // Memory is disabled during stall, so the pending word is frozen on the first stall edge.
        if (req_valid && !hold_valid) begin
          hold_instr <= bus.imem_rdata;
          hold_valid <= 1'b1;
        end
      end else begin
        pc_q       <= pc_q + PC_STEP;
        req_pc     <= pc_q;
        req_valid  <= 1'b1;
        hold_valid <= 1'b0;
      end
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.imem_en      = !bus.stall || bus.PcSel;
  assign bus.if_pc        = req_pc;
  assign bus.if_valid     = if_valid;
  // Invalid slots present zero rather than whatever the memory bus carries.
  assign bus.if_instr     = hold_valid ? hold_instr : (req_valid ? bus.imem_rdata : '0);
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random and directed stimulus checked against a PC-stream reference model.
// Rev 1.0
`default_nettype none

module tb_fetch_stage;

  localparam int PC_W    = 9;
  localparam int INSTR_W = 32;
  localparam int WORDS   = (1 << PC_W) / 4;

  logic clk;
  logic reset;

  fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory; returns garbage on cycles it was not enabled.
  logic [INSTR_W-1:0] mem [0:WORDS-1];
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr[PC_W-1:2]];
    else             bus.imem_rdata <= $urandom;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: next fetch address, instruction being presented, counters.
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_out_pc;
  logic            m_valid;
  logic            m_mis;
  logic [31:0]     m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = '0;
    m_out_pc = '0;
    m_valid  = 1'b0;
    m_mis    = 1'b0;
    m_cnt    = '0;
  endtask

  task automatic cyc(input logic rst_v, input logic st, input logic ps, input logic [31:0] br);
    logic [INSTR_W-1:0] exp_instr;
    reset     = rst_v;
    bus.stall = st;
    bus.PcSel = ps;
    bus.BrPC  = br;
    #1;
    exp_instr = m_valid ? mem[m_out_pc[PC_W-1:2]] : '0;
    check("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
    check("imem_en", 64'(bus.imem_en), 64'(!st || ps));
    check("if_valid", 64'(bus.if_valid), 64'(m_valid));
    check("if_pc", 64'(bus.if_pc), 64'(m_out_pc));
    check("if_instr", 64'(bus.if_instr), 64'(exp_instr));
    check("misalign_err", 64'(bus.misalign_err), 64'(m_mis));
    check("fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
    @(posedge clk);
    if (!rst_v) begin
      model_reset();
    end else begin
      if (m_valid && !st && !ps) m_cnt = m_cnt + 32'd1;
      m_mis = ps && (br[1:0] != 2'b00);
      if (ps) begin
        m_pc    = {br[PC_W-1:2], 2'b00};
        m_valid = 1'b0;
      end else if (!st) begin
        m_out_pc = m_pc;
        m_valid  = 1'b1;
        m_pc     = m_pc + PC_W'(4);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[9'h050 >> 2] = 32'hDEADBEEF;
    reset     = 1'b0;
    bus.stall = 1'b0;
    bus.PcSel = 1'b0;
    bus.BrPC  = '0;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset for 3 cycles, then free-run past the PC wrap at 0x1FC.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 140; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Walk to the 0xDEADBEEF word and stall on it for 4 cycles.
    for (int i = 0; i < 200 && !(m_valid && m_out_pc == 9'h050); i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("reach_0x050", 64'(m_valid && m_out_pc == 9'h050), 64'd1);
    check("deadbeef", 64'(bus.if_instr), 64'hDEADBEEF);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect to 0x40 while stalled.
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Misaligned redirect target.
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0046);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Back-to-back redirects, then reset in the middle of a redirect.
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0010);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0080);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FF21);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic rv, sv, pv;
      rv = ($urandom_range(0, 99) != 0);
      sv = ($urandom_range(0, 9) < 3);
      pv = ($urandom_range(0, 9) == 0);
      cyc(rv, sv, pv, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
